// File: rtl/pipeline_mem_stage.sv
// MEM stage with the MEM/WB pipeline register: word-organised data RAM with
// little-endian half/byte access, sign/zero-extended loads and fault reporting.
module pipeline_mem_stage #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  MEM_RegDst,
   input  logic [1:0]  MEM_MemtoReg,
   input  logic        MEM_RegWrite,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [1:0]  MEM_MemSize,
   input  logic        MEM_MemSigned,
   input  logic [31:0] MEM_ALUOut,
   input  logic [31:0] MEM_WrData,
   input  logic [31:0] MEM_PC,
   input  logic [4:0]  MEM_WrReg,
   input  logic        stall,
   input  logic        flush,
   output logic [1:0]  WB_RegDst,
   output logic [1:0]  WB_MemtoReg,
   output logic        WB_RegWrite,
   output logic [31:0] WB_inA,
   output logic [31:0] WB_inB,
   output logic [31:0] WB_PC,
   output logic [4:0]  WB_WrReg,
   output logic        mem_fault
);

   logic [31:0]   ram [0:DEPTH-1];

   logic [AW-1:0] wordIdx;
   logic [1:0]    lane;
   logic          outOfRange;
   logic          misaligned;
   logic          fault;
   logic          access;
   logic [31:0]   ramWord;
   logic [15:0]   loadHalf;
   logic [7:0]    loadByte;
   logic [31:0]   loadData;
   logic [31:0]   storeWord;
   logic [3:0]    byteEn;
   logic          doStore;

   always_comb begin
      wordIdx    = MEM_ALUOut[AW+1:2];
      lane       = MEM_ALUOut[1:0];
      outOfRange = (MEM_ALUOut >= 32'(4 * DEPTH));
      case (MEM_MemSize)
         2'd1:    misaligned = lane[0];
         2'd2:    misaligned = 1'b0;
         default: misaligned = (lane != 2'd0);
      endcase
      fault  = outOfRange | misaligned;
      access = MEM_MemRead | MEM_MemWrite;

      // Read is asynchronous, so a same-cycle store to this word is not yet visible.
      ramWord  = ram[wordIdx];
      loadHalf = lane[1] ? ramWord[31:16] : ramWord[15:0];
      loadByte = ramWord[{lane, 3'b000} +: 8];

      loadData = '0;
      if (MEM_MemRead && !fault) begin
         case (MEM_MemSize)
            2'd1:    loadData = {{16{MEM_MemSigned & loadHalf[15]}}, loadHalf};
            2'd2:    loadData = {{24{MEM_MemSigned & loadByte[7]}}, loadByte};
            default: loadData = ramWord;
         endcase
      end

      // Store data is replicated across lanes; byte enables pick the addressed ones.
      case (MEM_MemSize)
         2'd1: begin
            storeWord = {2{MEM_WrData[15:0]}};
            byteEn    = lane[1] ? 4'b1100 : 4'b0011;
         end
         2'd2: begin
            storeWord = {4{MEM_WrData[7:0]}};
            byteEn    = 4'b0001 << lane;
         end
         default: begin
            storeWord = MEM_WrData;
            byteEn    = 4'b1111;
         end
      endcase

      doStore = MEM_MemWrite & ~fault & ~stall & ~flush & ~reset;
   end

   always_ff @(posedge clk) begin
      if (doStore) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (byteEn[k]) ram[wordIdx][8*k +: 8] <= storeWord[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         WB_RegDst   <= '0;
         WB_MemtoReg <= '0;
         WB_RegWrite <= 1'b0;
         WB_inA      <= '0;
         WB_inB      <= '0;
         WB_PC       <= '0;
         WB_WrReg    <= '0;
         mem_fault   <= 1'b0;
      end else if (stall) begin
         mem_fault   <= 1'b0;
      end else begin
         WB_RegDst   <= MEM_RegDst;
         WB_MemtoReg <= MEM_MemtoReg;
         WB_RegWrite <= MEM_RegWrite & ~(access & fault);
         WB_inA      <= MEM_ALUOut;
         WB_inB      <= loadData;
         WB_PC       <= MEM_PC;
         WB_WrReg    <= MEM_WrReg;
         mem_fault   <= access & fault;
      end
   end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Bench for pipeline_mem_stage: byte-addressed reference model checked every
// cycle, plus directed instruction sequence with hand-computed expectations.
module tb_pipeline_mem_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  MEM_RegDst = '0;
   logic [1:0]  MEM_MemtoReg = '0;
   logic        MEM_RegWrite = 1'b0;
   logic        MEM_MemRead = 1'b0;
   logic        MEM_MemWrite = 1'b0;
   logic [1:0]  MEM_MemSize = '0;
   logic        MEM_MemSigned = 1'b0;
   logic [31:0] MEM_ALUOut = '0;
   logic [31:0] MEM_WrData = '0;
   logic [31:0] MEM_PC = '0;
   logic [4:0]  MEM_WrReg = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  WB_RegDst;
   logic [1:0]  WB_MemtoReg;
   logic        WB_RegWrite;
   logic [31:0] WB_inA;
   logic [31:0] WB_inB;
   logic [31:0] WB_PC;
   logic [4:0]  WB_WrReg;
   logic        mem_fault;

   int nChecks = 0;
   int nFails  = 0;

   pipeline_mem_stage #(.DEPTH(256), .AW(8)) dut (
      .clk(clk), .reset(reset),
      .MEM_RegDst(MEM_RegDst), .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_MemSize(MEM_MemSize),
      .MEM_MemSigned(MEM_MemSigned), .MEM_ALUOut(MEM_ALUOut), .MEM_WrData(MEM_WrData),
      .MEM_PC(MEM_PC), .MEM_WrReg(MEM_WrReg), .stall(stall), .flush(flush),
      .WB_RegDst(WB_RegDst), .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite),
      .WB_inA(WB_inA), .WB_inB(WB_inB), .WB_PC(WB_PC), .WB_WrReg(WB_WrReg),
      .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: 1024-byte memory, outputs derived from the access rules.
   logic [7:0]  mb [0:1023];
   logic [1:0]  eRegDst = '0, eMemtoReg = '0;
   logic        eRegWrite = 1'b0, eFault = 1'b0;
   logic [31:0] eInA = '0, eInB = '0, ePC = '0;
   logic [4:0]  eWrReg = '0;

   initial for (int i = 0; i < 1024; i++) mb[i] = 8'h00;

   always @(posedge clk) begin : model
      int unsigned a;
      bit          bad;
      bit          acc;
      logic [31:0] ld;
      int unsigned nBytes;
      a      = MEM_ALUOut;
      nBytes = (MEM_MemSize == 2'd1) ? 2 : (MEM_MemSize == 2'd2) ? 1 : 4;
      bad    = (a >= 1024) || (a % nBytes != 0);
      acc    = MEM_MemRead || MEM_MemWrite;
      ld     = 0;
      if (MEM_MemRead && !bad) begin
         for (int unsigned b = 0; b < nBytes; b++) ld[8*b +: 8] = mb[a + b];
         if (MEM_MemSigned && nBytes == 2 && ld[15]) ld = ld | 32'hFFFF0000;
         if (MEM_MemSigned && nBytes == 1 && ld[7])  ld = ld | 32'hFFFFFF00;
      end
      if (reset || flush) begin
         eRegDst = 0; eMemtoReg = 0; eRegWrite = 0; eInA = 0; eInB = 0;
         ePC = 0; eWrReg = 0; eFault = 0;
      end else if (stall) begin
         eFault = 0;
      end else begin
         eRegDst = MEM_RegDst; eMemtoReg = MEM_MemtoReg;
         eRegWrite = MEM_RegWrite && !(acc && bad);
         eInA = MEM_ALUOut; eInB = ld; ePC = MEM_PC; eWrReg = MEM_WrReg;
         eFault = acc && bad;
      end
      if (MEM_MemWrite && !bad && !stall && !flush && !reset)
         for (int unsigned b = 0; b < nBytes; b++) mb[a + b] = MEM_WrData[8*b +: 8];
      #1;
      chk("WB_RegDst",   32'(WB_RegDst),   32'(eRegDst));
      chk("WB_MemtoReg", 32'(WB_MemtoReg), 32'(eMemtoReg));
      chk("WB_RegWrite", 32'(WB_RegWrite), 32'(eRegWrite));
      chk("WB_inA",      WB_inA,           eInA);
      chk("WB_inB",      WB_inB,           eInB);
      chk("WB_PC",       WB_PC,            ePC);
      chk("WB_WrReg",    32'(WB_WrReg),    32'(eWrReg));
      chk("mem_fault",   32'(mem_fault),   32'(eFault));
   end

   // One instruction in MEM for one cycle; returns 2 time units after the edge.
   task automatic op(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                     input logic [31:0] addr, input logic [31:0] data,
                     input bit stl = 0, input bit fl = 0, input bit rst = 0);
      @(negedge clk);
      MEM_MemRead = rd; MEM_MemWrite = wr; MEM_MemSize = sz; MEM_MemSigned = sgn;
      MEM_ALUOut = addr; MEM_WrData = data;
      MEM_RegWrite = rd; MEM_MemtoReg = {1'b0, rd}; MEM_RegDst = 2'd1;
      MEM_WrReg = 5'(addr[6:2] + 5'd3); MEM_PC = 32'h0040_0000 + addr;
      stall = stl; flush = fl; reset = rst;
      @(posedge clk);
      #2;
   endtask

   initial begin
      // reset for two cycles with random stimulus
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         {MEM_RegDst, MEM_MemtoReg, MEM_RegWrite, MEM_MemSize, MEM_MemSigned} = 8'($urandom);
         MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0;
         MEM_ALUOut = $urandom; MEM_WrData = $urandom; MEM_PC = $urandom;
         MEM_WrReg = 5'($urandom); stall = 1'b0; flush = 1'b0; reset = 1'b1;
         @(posedge clk); #2;
         chk("rst_RegWrite", 32'(WB_RegWrite), 32'h0);
         chk("rst_inA", WB_inA, 32'h0);
         chk("rst_fault", 32'(mem_fault), 32'h0);
      end
      op(0, 0, 2'd0, 0, 32'h55, 32'h0);
      chk("noacc_inA", WB_inA, 32'h55);
      chk("noacc_PC", WB_PC, 32'h0040_0055);

      op(0, 1, 2'd0, 0, 32'h0,  32'h1122_3344);          // SW @0
      op(0, 1, 2'd0, 0, 32'h10, 32'hDEAD_BEEF);          // SW @0x10
      op(1, 0, 2'd0, 0, 32'h10, 32'h0);                  // LW 0x10
      chk("lw_inB", WB_inB, 32'hDEAD_BEEF);
      chk("lw_RegWrite", 32'(WB_RegWrite), 32'h1);

      op(0, 1, 2'd2, 0, 32'h13, 32'h1234_5680);          // SB 0x80 @0x13
      op(1, 0, 2'd2, 1, 32'h13, 32'h0);                  // LB
      chk("lb_inB", WB_inB, 32'hFFFF_FF80);
      op(1, 0, 2'd2, 0, 32'h13, 32'h0);                  // LBU
      chk("lbu_inB", WB_inB, 32'h0000_0080);
      op(1, 0, 2'd1, 1, 32'h12, 32'h0);                  // LH 0x12 -> bytes AD,80
      chk("lh_inB", WB_inB, 32'hFFFF_80AD);
      op(1, 0, 2'd1, 0, 32'h10, 32'h0);                  // LHU 0x10
      chk("lhu_inB", WB_inB, 32'h0000_BEEF);
      op(1, 0, 2'd0, 0, 32'h10, 32'h0);
      chk("lw_merged", WB_inB, 32'h80AD_BEEF);

      op(1, 0, 2'd0, 0, 32'h11, 32'h0);                  // misaligned LW
      chk("mis_fault", 32'(mem_fault), 32'h1);
      chk("mis_inB", WB_inB, 32'h0);
      chk("mis_RegWrite", 32'(WB_RegWrite), 32'h0);
      op(1, 0, 2'd1, 0, 32'h13, 32'h0);                  // misaligned LH
      chk("mish_fault", 32'(mem_fault), 32'h1);
      op(0, 1, 2'd0, 0, 32'h400, 32'hFFFF_FFFF);         // out of range SW
      chk("oor_fault", 32'(mem_fault), 32'h1);
      op(1, 0, 2'd0, 0, 32'h0, 32'h0);
      chk("oor_nowrap", WB_inB, 32'h1122_3344);
      chk("fault_pulse", 32'(mem_fault), 32'h0);

      op(0, 1, 2'd0, 0, 32'h20, 32'h1234_5678, 1);       // stalled SW
      chk("stall_hold_inA", WB_inA, 32'h0);
      chk("stall_hold_inB", WB_inB, 32'h1122_3344);
      op(1, 0, 2'd0, 0, 32'h20, 32'h0);
      chk("stall_nostore", WB_inB, 32'h0);
      op(0, 1, 2'd0, 0, 32'h20, 32'h1234_5678);
      op(1, 0, 2'd0, 0, 32'h20, 32'h0);
      chk("stall_release", WB_inB, 32'h1234_5678);
      op(0, 1, 2'd1, 0, 32'h22, 32'hCAFE_BEEF);          // SH @0x22
      op(1, 0, 2'd0, 0, 32'h20, 32'h0);
      chk("sh_merge", WB_inB, 32'hBEEF_5678);

      op(0, 1, 2'd0, 0, 32'h30, 32'hAAAA_AAAA, 1, 1);    // flush + stall + SW
      chk("flush_RegWrite", 32'(WB_RegWrite), 32'h0);
      chk("flush_inA", WB_inA, 32'h0);
      chk("flush_PC", WB_PC, 32'h0);
      op(1, 0, 2'd0, 0, 32'h30, 32'h0);
      chk("flush_nostore", WB_inB, 32'h0);

      op(0, 1, 2'd0, 0, 32'h40, 32'h5555_5555, 1, 0, 1); // reset mid-stall store
      chk("rst_store_inA", WB_inA, 32'h0);
      op(1, 0, 2'd0, 0, 32'h40, 32'h0);
      chk("rst_nostore", WB_inB, 32'h0);
      op(1, 0, 2'd0, 0, 32'h3FC, 32'h0);                 // last word in range
      chk("top_fault", 32'(mem_fault), 32'h0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
